// File: rtl/ps2_teclado_rx.sv
// ps2_teclado_rx - PS/2 keyboard receiver (device-to-host frames).
//
// Deserializes start/8 data (LSB first)/odd parity/stop frames from the raw
// PS/2 pins into scan codes on the Tecla bus.
//
// Optional feature macro: BREAK_FILTER_EN
//   When defined, an F0 (break) prefix is absorbed and the following byte is
//   presented with tecla_suelta=1. When undefined, every byte is output raw
//   and tecla_suelta is tied 0.
//
// Ports:
//   clk           in   system clock
//   reset         in   asynchronous active-high reset
//   ps2_clk       in   raw PS/2 clock pin (asynchronous)
//   ps2_data      in   raw PS/2 data pin (asynchronous)
//   tecla         out  [7:0] last accepted scan code, held until the next one
//   tecla_valida  out  one-cycle pulse when tecla is updated
//   tecla_suelta  out  release flag for the current tecla (feature only)
//   error_trama   out  one-cycle pulse on parity/start/stop/timeout error
//   ocupado       out  high while a frame is in progress
module ps2_teclado_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int TO_W           = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] tecla,
  output logic       tecla_valida,
  output logic       tecla_suelta,
  output logic       error_trama,
  output logic       ocupado
);

  localparam int FW = $clog2(FILTER_LEN) + 1;
  localparam logic [FW-1:0]   F_LAST  = FW'(FILTER_LEN - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2, STOP = 2'd3} state_t;

  logic          clk_meta, clk_sync, data_meta, data_sync;
  logic          filt;
  logic [FW-1:0] fcnt;
  logic          fall;

  state_t        state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_ok;
  logic [TO_W-1:0] to_cnt;

  // Two-stage synchronizers; idle PS/2 lines are high, so reset to 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_meta  <= ps2_clk;
      clk_sync  <= clk_meta;
      data_meta <= ps2_data;
      data_sync <= data_meta;
    end
  end

  // Stability filter: fcnt counts consecutive samples that disagree with
  // filt; the FILTER_LEN-th disagreeing sample flips the filtered level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt <= 1'b1;
      fcnt <= '0;
    end else if (clk_sync == filt) begin
      fcnt <= '0;
    end else if (fcnt == F_LAST) begin
      filt <= clk_sync;
      fcnt <= '0;
    end else begin
      fcnt <= fcnt + 1'b1;
    end
  end

  // Edge cycle: the cycle in which the filtered clock is about to go 1->0.
  assign fall = filt & ~clk_sync & (fcnt == F_LAST);

  assign ocupado = (state != IDLE);

`ifdef BREAK_FILTER_EN
  logic brk;
`else
  assign tecla_suelta = 1'b0;
`endif

  // Frame FSM with timeout and registered Tecla bus outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      bit_cnt      <= 3'd0;
      shreg        <= 8'h00;
      par_ok       <= 1'b0;
      to_cnt       <= '0;
      tecla        <= 8'hFF;
      tecla_valida <= 1'b0;
      error_trama  <= 1'b0;
`ifdef BREAK_FILTER_EN
      tecla_suelta <= 1'b0;
      brk          <= 1'b0;
`endif
    end else begin
      tecla_valida <= 1'b0;
      error_trama  <= 1'b0;

      if (state == IDLE || fall) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end

      if (state != IDLE && !fall && to_cnt == TO_LAST) begin
        // Line went quiet mid-frame: drop the partial byte.
        state       <= IDLE;
        error_trama <= 1'b1;
      end else if (fall) begin
        case (state)
          IDLE: begin
            if (!data_sync) begin
              state   <= DATA;
              bit_cnt <= 3'd0;
            end
          end
          DATA: begin
            shreg   <= {data_sync, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state <= PARITY;
            end
          end
          PARITY: begin
            par_ok <= ^{shreg, data_sync};
            state  <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (data_sync && par_ok) begin
`ifdef BREAK_FILTER_EN
              if (shreg == 8'hF0) begin
                brk <= 1'b1;
              end else begin
                tecla        <= shreg;
                tecla_valida <= 1'b1;
                tecla_suelta <= brk;
                brk          <= 1'b0;
              end
`else
              tecla        <= shreg;
              tecla_valida <= 1'b1;
`endif
            end else begin
              error_trama <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_teclado_rx.sv
// tb_ps2_teclado_rx - directed bench for ps2_teclado_rx with a scoreboard of
// expected {suelta, tecla} entries popped on every tecla_valida pulse.
module tb_ps2_teclado_rx;

  localparam int FLEN = 8;
  localparam int TO   = 300;
  localparam int HALF = 40;   // PS/2 half period in clk cycles (scaled down)

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] tecla;
  logic       tecla_valida, tecla_suelta, error_trama, ocupado;

  int compared = 0;
  int mismatched = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  logic [8:0] sb[$];

  ps2_teclado_rx #(.FILTER_LEN(FLEN), .TIMEOUT_CYCLES(TO), .TO_W(16)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .tecla(tecla), .tecla_valida(tecla_valida), .tecla_suelta(tecla_suelta),
    .error_trama(error_trama), .ocupado(ocupado)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor, sampled on the falling clk edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (tecla_valida && error_trama) begin
        chk("valid_and_error", 32'(tecla_valida & error_trama), 32'd0);
      end
      if (error_trama) err_cnt++;
      if (tecla_valida) begin
        logic [8:0] e;
        valid_cnt++;
        if (sb.size() == 0) begin
          chk("unexpected_valid", 32'(tecla), 32'h1FF);
        end else begin
          e = sb.pop_front();
          chk("tecla", 32'(tecla), 32'(e[7:0]));
          chk("suelta", 32'(tecla_suelta), 32'(e[8]));
        end
      end
    end
  end

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
    logic p;
    p = (~^b) ^ bad_par;
    return {~bad_stop, p, b, 1'b0};
  endfunction

  // Sends the first n bits of a frame; optional glitches on bit 3.
  task automatic send_bits(input logic [10:0] bits, input int n, input bit glitch);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      repeat (HALF / 2) @(posedge clk);
      if (glitch && i == 3) begin
        ps2_clk = 1'b0; repeat (FLEN - 1) @(posedge clk); ps2_clk = 1'b1;
      end
      repeat (HALF / 2) @(posedge clk);
      ps2_clk = 1'b0;
      repeat (HALF / 2) @(posedge clk);
      if (glitch && i == 3) begin
        ps2_clk = 1'b1; repeat (FLEN - 1) @(posedge clk); ps2_clk = 1'b0;
      end
      repeat (HALF / 2) @(posedge clk);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop, input bit glitch);
    send_bits(mk_frame(b, bad_par, bad_stop), 11, glitch);
    ps2_data = 1'b1;
    repeat (4 * HALF) @(posedge clk);
  endtask

  initial begin
    int v0, e0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tecla", 32'(tecla), 32'hFF);
    chk("rst_valida", 32'(tecla_valida), 32'd0);
    chk("rst_error", 32'(error_trama), 32'd0);
    chk("rst_ocupado", 32'(ocupado), 32'd0);
    chk("rst_suelta", 32'(tecla_suelta), 32'd0);
    reset = 1'b0;
    repeat (5) @(posedge clk);

    // 1: clean 0x70
    v0 = valid_cnt; e0 = err_cnt;
    sb.push_back({1'b0, 8'h70});
    send_frame(8'h70, 1'b0, 1'b0, 1'b0);
    chk("t1_tecla", 32'(tecla), 32'h70);
    chk("t1_valids", 32'(valid_cnt - v0), 32'd1);
    chk("t1_errors", 32'(err_cnt - e0), 32'd0);

    // 2: 0x1C with flipped parity, then 0x1C with bad stop
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(8'h1C, 1'b1, 1'b0, 1'b0);
    chk("t2_parity_err", 32'(err_cnt - e0), 32'd1);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    chk("t2_stop_err", 32'(err_cnt - e0), 32'd2);
    chk("t2_valids", 32'(valid_cnt - v0), 32'd0);
    chk("t2_tecla_held", 32'(tecla), 32'h70);

    // 3: F0 then 70
    v0 = valid_cnt;
`ifdef BREAK_FILTER_EN
    sb.push_back({1'b1, 8'h70});
`else
    sb.push_back({1'b0, 8'hF0});
    sb.push_back({1'b0, 8'h70});
`endif
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h70, 1'b0, 1'b0, 1'b0);
`ifdef BREAK_FILTER_EN
    chk("t3_valids", 32'(valid_cnt - v0), 32'd1);
`else
    chk("t3_valids", 32'(valid_cnt - v0), 32'd2);
`endif

    // 4: partial frame then timeout, then clean 0x5A
    e0 = err_cnt;
    send_bits(mk_frame(8'h5A, 1'b0, 1'b0), 6, 1'b0);
    ps2_data = 1'b1;
    repeat (TO / 2) @(posedge clk);
    #1;
    chk("t4_busy", 32'(ocupado), 32'd1);
    repeat (TO) @(posedge clk);
    #1;
    chk("t4_timeout_err", 32'(err_cnt - e0), 32'd1);
    chk("t4_idle", 32'(ocupado), 32'd0);
    sb.push_back({1'b0, 8'h5A});
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
    chk("t4_tecla", 32'(tecla), 32'h5A);

    // 5: reset after the 4th data bit
    send_bits(mk_frame(8'h70, 1'b0, 1'b0), 5, 1'b0);
    #3 reset = 1'b1;
    #1;
    chk("t5_tecla", 32'(tecla), 32'hFF);
    chk("t5_ocupado", 32'(ocupado), 32'd0);
    chk("t5_valida", 32'(tecla_valida), 32'd0);
    chk("t5_error", 32'(error_trama), 32'd0);
    ps2_data = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    repeat (4 * HALF) @(posedge clk);
    sb.push_back({1'b0, 8'h70});
    send_frame(8'h70, 1'b0, 1'b0, 1'b0);
    chk("t5_after", 32'(tecla), 32'h70);

    // 6: glitches on an idle line (data low) and mid-frame
    e0 = err_cnt;
    ps2_data = 1'b0;
    repeat (10) @(posedge clk);
    ps2_clk = 1'b0; repeat (FLEN - 1) @(posedge clk); ps2_clk = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("t6_idle_glitch", 32'(ocupado), 32'd0);
    ps2_data = 1'b1;
    repeat (HALF) @(posedge clk);
    sb.push_back({1'b0, 8'h3C});
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    chk("t6_tecla", 32'(tecla), 32'h3C);
    chk("t6_errors", 32'(err_cnt - e0), 32'd0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
